// File: rtl/idx_reg_bank.sv
// Index/stack-pointer register bank with a single-outstanding memory port.
// Field ops finish in IDLE; memory, push and pop ops walk IDLE -> MEM -> RESP.
module idx_reg_bank #(
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned NUM_IDX  = 2,
    parameter int unsigned WAIT_MAX = 15,
    localparam int unsigned ADDR_W  = 3 * DATA_W,
    localparam int unsigned SP_W    = 2 * DATA_W,
    localparam int unsigned IW      = $clog2(NUM_IDX + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd_op,
    input  logic [IW-1:0]             cmd_idx,
    input  logic [1:0]                cmd_field,
    input  logic [1:0]                cmd_post,
    input  logic [DATA_W-1:0]         cmd_data,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_ack,
    output logic [NUM_IDX*ADDR_W-1:0] idx_flat,
    output logic [SP_W-1:0]           sp
);

    localparam int unsigned CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    localparam logic [2:0] OP_WR_FIELD = 3'd0;
    localparam logic [2:0] OP_RD_FIELD = 3'd1;
    localparam logic [2:0] OP_MEM_RD   = 3'd2;
    localparam logic [2:0] OP_MEM_WR   = 3'd3;
    localparam logic [2:0] OP_PUSH     = 3'd4;
    localparam logic [2:0] OP_POP      = 3'd5;

    localparam logic [1:0] FLD_L    = 2'd0;
    localparam logic [1:0] FLD_H    = 2'd1;
    localparam logic [1:0] FLD_P    = 2'd2;
    localparam logic [1:0] FLD_RSVD = 2'd3;

    localparam logic [1:0] POST_INC = 2'd1;
    localparam logic [1:0] POST_DEC = 2'd2;

    typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

    state_t                         state_q, state_n;
    logic [NUM_IDX-1:0][ADDR_W-1:0] idx_q, idx_n;
    logic [SP_W-1:0]                sp_q, sp_n;
    logic [CNT_W-1:0]               wait_q, wait_n;
    logic [2:0]                     pend_op_q, pend_op_n;
    logic [IW-1:0]                  pend_idx_q, pend_idx_n;
    logic [1:0]                     pend_post_q, pend_post_n;
    logic                           err_q, err_n;

    logic                           cmd_ready_n, rsp_valid_n, rsp_err_n, mem_req_n, mem_we_n;
    logic [DATA_W-1:0]              rsp_data_n, mem_wdata_n, rd_val;
    logic [ADDR_W-1:0]              mem_addr_n, sel_idx, wr_idx, pend_reg, pend_mod;
    logic [SP_W-1:0]                sp_wr, sp_dec, pend_low;
    logic                           is_sp, idx_bad, illegal;

    assign idx_flat = idx_q;
    assign sp       = sp_q;
    assign sp_dec   = sp_q - SP_W'(1);

    // Register selected by the offered command and by the pending memory op
    always_comb begin
        sel_idx  = '0;
        pend_reg = '0;
        for (int i = 0; i < NUM_IDX; i++) begin
            if (cmd_idx == IW'(i))    sel_idx  = idx_q[i];
            if (pend_idx_q == IW'(i)) pend_reg = idx_q[i];
        end
    end

    always_comb begin
        is_sp   = (cmd_idx == IW'(NUM_IDX));
        idx_bad = (cmd_idx > IW'(NUM_IDX));
        case (cmd_op)
            OP_WR_FIELD, OP_RD_FIELD:
                illegal = idx_bad || (cmd_field == FLD_RSVD) || (is_sp && (cmd_field == FLD_P));
            OP_MEM_RD, OP_MEM_WR:
                illegal = idx_bad || is_sp;
            OP_PUSH, OP_POP:
                illegal = 1'b0;
            default:
                illegal = 1'b1;
        endcase
    end

    // Field merge/extract for WR_FIELD and RD_FIELD
    always_comb begin
        wr_idx = sel_idx;
        sp_wr  = sp_q;
        rd_val = sel_idx[DATA_W-1:0];
        case (cmd_field)
            FLD_L: begin
                wr_idx[DATA_W-1:0] = cmd_data;
                sp_wr[DATA_W-1:0]  = cmd_data;
                rd_val = is_sp ? sp_q[DATA_W-1:0] : sel_idx[DATA_W-1:0];
            end
            FLD_H: begin
                wr_idx[SP_W-1:DATA_W] = cmd_data;
                sp_wr[SP_W-1:DATA_W]  = cmd_data;
                rd_val = is_sp ? sp_q[SP_W-1:DATA_W] : sel_idx[SP_W-1:DATA_W];
            end
            FLD_P: begin
                wr_idx[ADDR_W-1:SP_W] = cmd_data;
                rd_val = sel_idx[ADDR_W-1:SP_W];
            end
            default: ;
        endcase
    end

    // Post-modify touches only the low H:L byte; page field rides along
    always_comb begin
        pend_low = pend_reg[SP_W-1:0];
        case (pend_post_q)
            POST_INC: pend_low = pend_reg[SP_W-1:0] + SP_W'(1);
            POST_DEC: pend_low = pend_reg[SP_W-1:0] - SP_W'(1);
            default:  ;
        endcase
        pend_mod = {pend_reg[ADDR_W-1:SP_W], pend_low};
    end

    always_comb begin
        state_n     = state_q;
        idx_n       = idx_q;
        sp_n        = sp_q;
        wait_n      = wait_q;
        pend_op_n   = pend_op_q;
        pend_idx_n  = pend_idx_q;
        pend_post_n = pend_post_q;
        err_n       = err_q;
        rsp_valid_n = 1'b0;
        rsp_err_n   = 1'b0;
        rsp_data_n  = rsp_data;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (illegal) begin
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                    end else begin
                        case (cmd_op)
                            OP_WR_FIELD: begin
                                rsp_valid_n = 1'b1;
                                if (is_sp) sp_n = sp_wr;
                                for (int i = 0; i < NUM_IDX; i++)
                                    if (cmd_idx == IW'(i)) idx_n[i] = wr_idx;
                            end
                            OP_RD_FIELD: begin
                                rsp_valid_n = 1'b1;
                                rsp_data_n  = rd_val;
                            end
                            default: begin
                                state_n     = MEM;
                                mem_req_n   = 1'b1;
                                mem_we_n    = (cmd_op == OP_MEM_WR) || (cmd_op == OP_PUSH);
                                mem_wdata_n = cmd_data;
                                wait_n      = '0;
                                err_n       = 1'b0;
                                pend_op_n   = cmd_op;
                                pend_idx_n  = cmd_idx;
                                pend_post_n = cmd_post;
                                case (cmd_op)
                                    OP_PUSH: mem_addr_n = ADDR_W'(sp_dec);
                                    OP_POP:  mem_addr_n = ADDR_W'(sp_q);
                                    default: mem_addr_n = sel_idx;
                                endcase
                            end
                        endcase
                    end
                end
            end
            MEM: begin
                if (mem_ack) begin
                    state_n   = RESP;
                    mem_req_n = 1'b0;
                    mem_we_n  = 1'b0;
                    case (pend_op_q)
                        OP_MEM_RD, OP_MEM_WR: begin
                            if (pend_op_q == OP_MEM_RD) rsp_data_n = mem_rdata;
                            for (int i = 0; i < NUM_IDX; i++)
                                if (pend_idx_q == IW'(i)) idx_n[i] = pend_mod;
                        end
                        OP_PUSH: sp_n = sp_dec;
                        OP_POP: begin
                            rsp_data_n = mem_rdata;
                            sp_n       = sp_q + SP_W'(1);
                        end
                        default: ;
                    endcase
                end else if (wait_q == CNT_W'(WAIT_MAX)) begin
                    // Timeout: abandon the access with no architectural change
                    state_n   = RESP;
                    mem_req_n = 1'b0;
                    mem_we_n  = 1'b0;
                    err_n     = 1'b1;
                end else begin
                    wait_n = wait_q + CNT_W'(1);
                end
            end
            RESP: begin
                rsp_valid_n = 1'b1;
                rsp_err_n   = err_q;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase

        cmd_ready_n = (state_n == IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            sp_q        <= '0;
            wait_q      <= '0;
            pend_op_q   <= '0;
            pend_idx_q  <= '0;
            pend_post_q <= '0;
            err_q       <= 1'b0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_data    <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            state_q     <= state_n;
            idx_q       <= idx_n;
            sp_q        <= sp_n;
            wait_q      <= wait_n;
            pend_op_q   <= pend_op_n;
            pend_idx_q  <= pend_idx_n;
            pend_post_q <= pend_post_n;
            err_q       <= err_n;
            cmd_ready   <= cmd_ready_n;
            rsp_valid   <= rsp_valid_n;
            rsp_err     <= rsp_err_n;
            rsp_data    <= rsp_data_n;
            mem_req     <= mem_req_n;
            mem_we      <= mem_we_n;
            mem_addr    <= mem_addr_n;
            mem_wdata   <= mem_wdata_n;
        end
    end

endmodule
